// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared state encoding, colours and pixel width for the mole sprite layer
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISING  = 3'd1,
    ST_UP      = 3'd2,
    ST_HIT     = 3'd3,
    ST_FALLING = 3'd4
  } mole_state_t;

  localparam logic [23:0] MOLE_RGB = 24'h8B5A2B;
  localparam logic [23:0] HIT_RGB  = 24'hFF2020;
  localparam int          PIX_W    = 10;

endpackage

// File: rtl/mole_fsm.sv
// rtl/mole_fsm.sv - per-hole mole animation state machine advancing once per frame
module mole_fsm
  import mole_pkg::*;
#(
  parameter int H          = 64,
  parameter int RISE_STEP  = 4,
  parameter int UP_FRAMES  = 60,
  parameter int HIT_FRAMES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic        whack,
  output mole_state_t state,
  output logic [7:0]  height,
  output logic        busy,
  output logic        hit,
  output logic        miss
);

  localparam logic [8:0] H9       = 9'(H);
  localparam logic [8:0] STEP9    = 9'(RISE_STEP);
  localparam logic [7:0] H8       = 8'(H);
  localparam logic [7:0] STEP8    = 8'(RISE_STEP);
  localparam logic [7:0] UP_LAST  = 8'(UP_FRAMES - 1);
  localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES - 1);

  mole_state_t state_n;
  logic [7:0]  height_n;
  logic [7:0]  timer;
  logic [7:0]  timer_n;
  logic        hit_n;
  logic        miss_n;

  // Widened sum so a step past H saturates instead of wrapping.
  logic [8:0]  rise_sum;
  logic [7:0]  rise_h;
  logic [7:0]  fall_h;

  assign rise_sum = {1'b0, height} + STEP9;
  assign rise_h   = (rise_sum >= H9) ? H8 : rise_sum[7:0];
  assign fall_h   = (height > STEP8) ? (height - STEP8) : 8'd0;
  assign busy     = (state != ST_IDLE);

  // State, height, frame timer and the one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      height <= 8'd0;
      timer  <= 8'd0;
      hit    <= 1'b0;
      miss   <= 1'b0;
    end else begin
      state  <= state_n;
      height <= height_n;
      timer  <= timer_n;
      hit    <= hit_n;
      miss   <= miss_n;
    end
  end

  // Next-state logic; a whack outranks a frame tick while the mole is exposed.
  always_comb begin
    state_n  = state;
    height_n = height;
    timer_n  = timer;
    hit_n    = 1'b0;
    miss_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spawn) begin
          state_n  = ST_RISING;
          height_n = 8'd0;
          timer_n  = 8'd0;
        end
      end
      ST_RISING: begin
        if (whack) begin
          state_n = ST_HIT;
          timer_n = 8'd0;
          hit_n   = 1'b1;
        end else if (frame_tick) begin
          height_n = rise_h;
          if (rise_h == H8) begin
            state_n = ST_UP;
            timer_n = 8'd0;
          end
        end
      end
      ST_UP: begin
        if (whack) begin
          state_n = ST_HIT;
          timer_n = 8'd0;
          hit_n   = 1'b1;
        end else if (frame_tick) begin
          if (timer == UP_LAST) begin
            state_n = ST_FALLING;
            miss_n  = 1'b1;
          end else begin
            timer_n = timer + 8'd1;
          end
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (timer == HIT_LAST) begin
            state_n = ST_FALLING;
          end else begin
            timer_n = timer + 8'd1;
          end
        end
      end
      ST_FALLING: begin
        if (frame_tick) begin
          height_n = fall_h;
          if (fall_h == 8'd0) begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        height_n = 8'd0;
        timer_n  = 8'd0;
      end
    endcase
  end

endmodule

// File: rtl/mole_layer.sv
// rtl/mole_layer.sv - mole sprite layer: animation FSM plus registered coverage test and colour mux
module mole_layer
  import mole_pkg::*;
#(
  parameter int HOLE_X     = 100,
  parameter int HOLE_Y     = 300,
  parameter int W          = 64,
  parameter int H          = 64,
  parameter int RISE_STEP  = 4,
  parameter int UP_FRAMES  = 60,
  parameter int HIT_FRAMES = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             spawn,
  input  logic             whack,
  input  logic [PIX_W-1:0] pixel_x,
  input  logic [PIX_W-1:0] pixel_y,
  output logic [23:0]      layer_rgb,
  output logic             layer_valid,
  output logic             busy,
  output logic             hit,
  output logic             miss
);

  localparam logic [10:0] X_LO = 11'(HOLE_X);
  localparam logic [10:0] X_HI = 11'(HOLE_X + W);
  localparam logic [10:0] Y_HI = 11'(HOLE_Y);

  mole_state_t state;
  logic [7:0]  height;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] y_lo;
  logic        covered;

  mole_fsm #(
    .H          (H),
    .RISE_STEP  (RISE_STEP),
    .UP_FRAMES  (UP_FRAMES),
    .HIT_FRAMES (HIT_FRAMES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .whack      (whack),
    .state      (state),
    .height     (height),
    .busy       (busy),
    .hit        (hit),
    .miss       (miss)
  );

  // 11-bit compare keeps HOLE_X+W and the pixel range free of wrap-around.
  assign px      = {1'b0, pixel_x};
  assign py      = {1'b0, pixel_y};
  assign y_lo    = Y_HI - {3'b000, height};
  assign covered = (state != ST_IDLE) && (height != 8'd0) &&
                   (px >= X_LO) && (px < X_HI) &&
                   (py >= y_lo) && (py < Y_HI);

  // One-cycle registered sprite output using the state held when the pixel was sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_valid <= 1'b0;
      layer_rgb   <= 24'd0;
    end else begin
      layer_valid <= covered;
      if (!covered) begin
        layer_rgb <= 24'd0;
      end else if (state == ST_HIT) begin
        layer_rgb <= HIT_RGB;
      end else begin
        layer_rgb <= MOLE_RGB;
      end
    end
  end

endmodule

// File: tb/tb_mole_layer.sv
// tb/tb_mole_layer.sv - self-checking bench for mole_layer against a behavioural mole model
module tb_mole_layer;

  localparam int HOLE_X     = 100;
  localparam int HOLE_Y     = 300;
  localparam int W          = 64;
  localparam int H          = 64;
  localparam int RISE_STEP  = 4;
  localparam int UP_FRAMES  = 60;
  localparam int HIT_FRAMES = 20;

  localparam logic [23:0] C_MOLE = 24'h8B5A2B;
  localparam logic [23:0] C_HIT  = 24'hFF2020;

  localparam int M_IDLE    = 0;
  localparam int M_RISING  = 1;
  localparam int M_UP      = 2;
  localparam int M_HIT     = 3;
  localparam int M_FALLING = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        spawn = 1'b0;
  logic        whack = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic [23:0] layer_rgb;
  logic        layer_valid;
  logic        busy;
  logic        hit;
  logic        miss;

  int vectors = 0;
  int miscompares = 0;

  int m_st = M_IDLE;
  int m_h = 0;
  int m_t = 0;
  logic        exp_hit;
  logic        exp_miss;
  logic [27:0] exp_vec;

  mole_layer #(
    .HOLE_X(HOLE_X), .HOLE_Y(HOLE_Y), .W(W), .H(H),
    .RISE_STEP(RISE_STEP), .UP_FRAMES(UP_FRAMES), .HIT_FRAMES(HIT_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn(spawn), .whack(whack),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
    .busy(busy), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  // Behavioural mole: one update per clock from the sampled controls.
  task automatic model_step(input bit r, input bit ft, input bit sp, input bit wh);
    exp_hit  = 1'b0;
    exp_miss = 1'b0;
    if (r) begin
      m_st = M_IDLE; m_h = 0; m_t = 0;
    end else if (m_st == M_IDLE) begin
      if (sp) begin m_st = M_RISING; m_h = 0; m_t = 0; end
    end else if ((m_st == M_RISING || m_st == M_UP) && wh) begin
      m_st = M_HIT; m_t = 0; exp_hit = 1'b1;
    end else if (ft) begin
      if (m_st == M_RISING) begin
        m_h = (m_h + RISE_STEP > H) ? H : m_h + RISE_STEP;
        if (m_h == H) begin m_st = M_UP; m_t = 0; end
      end else if (m_st == M_UP) begin
        m_t++;
        if (m_t == UP_FRAMES) begin m_st = M_FALLING; exp_miss = 1'b1; end
      end else if (m_st == M_HIT) begin
        m_t++;
        if (m_t == HIT_FRAMES) m_st = M_FALLING;
      end else begin
        m_h = (m_h - RISE_STEP < 0) ? 0 : m_h - RISE_STEP;
        if (m_h == 0) m_st = M_IDLE;
      end
    end
  endtask

  // Apply one cycle of stimulus, predict {busy,hit,miss,valid,rgb}, then step past the edge.
  task automatic drive_cycle(input bit r, input bit ft, input bit sp, input bit wh,
                             input int x, input int y);
    bit          cov;
    logic [23:0] col;
    pixel_x = 10'(x); pixel_y = 10'(y);
    rst = r; frame_tick = ft; spawn = sp; whack = wh;
    cov = !r && (m_st != M_IDLE) && (m_h > 0) && (x >= HOLE_X) && (x < HOLE_X + W) &&
          (y >= HOLE_Y - m_h) && (y < HOLE_Y);
    col = !cov ? 24'd0 : (m_st == M_HIT) ? C_HIT : C_MOLE;
    model_step(r, ft, sp, wh);
    exp_vec = {(m_st != M_IDLE), exp_hit, exp_miss, cov, col};
    @(posedge clk);
    #1;
    rst = 1'b0; frame_tick = 1'b0; spawn = 1'b0; whack = 1'b0;
  endtask

  function automatic int rx();
    return HOLE_X - 4 + int'($urandom_range(0, W + 8));
  endfunction

  function automatic int ry();
    return HOLE_Y - H - 4 + int'($urandom_range(0, H + 8));
  endfunction

  task automatic test_reset();
    drive_cycle(1, 0, 0, 0, 100, 250);
    drive_cycle(1, 1, 1, 1, 100, 250);
    vectors++;
    if ({busy, hit, miss, layer_valid, layer_rgb} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0000000", {busy, hit, miss, layer_valid, layer_rgb});
    end
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 12; c++) begin
        drive_cycle(0, (c == 11), 0, 0, rx(), ry());
        vectors++;
        if ({busy, layer_valid, layer_rgb} !== 26'd0) begin
          miscompares++;
          $display("FAIL idle_frames f%0d c%0d: got busy=%b valid=%b rgb=%h expected all 0",
                   f, c, busy, layer_valid, layer_rgb);
        end
      end
    end
  endtask

  task automatic test_rise();
    drive_cycle(0, 0, 1, 0, 100, 299);
    vectors++;
    if (busy !== 1'b1 || layer_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL spawn_busy: got busy=%b valid=%b expected busy=1 valid=0", busy, layer_valid);
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(0, 1, 0, 0, 100 + i, HOLE_Y - RISE_STEP * i);
      vectors++;
      if ({busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
        miscompares++;
        $display("FAIL rise_tick%0d: got %h expected %h", i, {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
      end
    end
    drive_cycle(0, 0, 0, 0, 100, 236);
    vectors++;
    if (layer_valid !== 1'b1 || layer_rgb !== C_MOLE) begin
      miscompares++;
      $display("FAIL up_pix_100_236: got valid=%b rgb=%h expected valid=1 rgb=%h", layer_valid, layer_rgb, C_MOLE);
    end
    drive_cycle(0, 0, 0, 0, 164, 240);
    vectors++;
    if (layer_valid !== 1'b0 || layer_rgb !== 24'd0) begin
      miscompares++;
      $display("FAIL up_pix_164_240: got valid=%b rgb=%h expected 0", layer_valid, layer_rgb);
    end
    drive_cycle(0, 0, 0, 0, 100, 300);
    vectors++;
    if (layer_valid !== 1'b0 || layer_rgb !== 24'd0) begin
      miscompares++;
      $display("FAIL up_pix_100_300: got valid=%b rgb=%h expected 0", layer_valid, layer_rgb);
    end
    drive_cycle(0, 0, 0, 0, 163, 299);
    vectors++;
    if (layer_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL up_pix_163_299: got valid=%b expected 1", layer_valid);
    end
    drive_cycle(0, 0, 0, 0, 100, 235);
    vectors++;
    if (layer_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL up_pix_100_235: got valid=%b expected 0", layer_valid);
    end
  endtask

  task automatic test_whack_hit();
    int hit_frames = 0;
    int fall_frames = 0;
    int misses = 0;
    drive_cycle(0, 0, 0, 1, 100, 236);
    vectors++;
    if (hit !== 1'b1 || layer_rgb !== C_MOLE || {busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
      miscompares++;
      $display("FAIL whack_up: got %h expected %h", {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
    end
    drive_cycle(0, 0, 0, 0, 120, 260);
    vectors++;
    if (hit !== 1'b0 || layer_rgb !== C_HIT) begin
      miscompares++;
      $display("FAIL hit_pulse_end: got hit=%b rgb=%h expected hit=0 rgb=%h", hit, layer_rgb, C_HIT);
    end
    for (int i = 0; i < 60 && busy; i++) begin
      drive_cycle(0, 1, 0, 0, 120, 299);
      if (layer_rgb === C_HIT) hit_frames++;
      else if (layer_rgb === C_MOLE) fall_frames++;
      if (miss) misses++;
      vectors++;
      if ({busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
        miscompares++;
        $display("FAIL hit_seq_tick%0d: got %h expected %h", i, {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
      end
    end
    vectors++;
    if (hit_frames != HIT_FRAMES || fall_frames != H / RISE_STEP || misses != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_timeline: got hit=%0d fall=%0d miss=%0d busy=%b expected %0d %0d 0 0",
               hit_frames, fall_frames, misses, busy, HIT_FRAMES, H / RISE_STEP);
    end
  endtask

  task automatic test_miss();
    int up_ticks = 0;
    int fall_ticks = 0;
    bit seen = 0;
    drive_cycle(0, 0, 1, 0, 100, 299);
    for (int i = 0; i < 16; i++) drive_cycle(0, 1, 0, 0, 100, 299);
    for (int i = 0; i < 200 && !seen; i++) begin
      drive_cycle(0, 1, 0, 0, rx(), ry());
      up_ticks++;
      if (miss) seen = 1;
      vectors++;
      if ({busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
        miscompares++;
        $display("FAIL up_tick%0d: got %h expected %h", i, {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
      end
    end
    drive_cycle(0, 0, 0, 0, 100, 299);
    vectors++;
    if (!seen || up_ticks != UP_FRAMES || miss !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_timing: got seen=%0d ticks=%0d miss_now=%b expected 1 %0d 0", seen, up_ticks, miss, UP_FRAMES);
    end
    for (int i = 0; i < 100 && busy; i++) begin
      drive_cycle(0, 1, 0, 0, 100, 299);
      fall_ticks++;
    end
    vectors++;
    if (fall_ticks != H / RISE_STEP || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_fall: got ticks=%0d busy=%b expected %0d 0", fall_ticks, busy, H / RISE_STEP);
    end
  endtask

  task automatic test_simultaneous();
    drive_cycle(0, 0, 1, 0, 100, 299);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 0, 0, 100, 299);
    drive_cycle(0, 1, 0, 1, 100, 280);
    vectors++;
    if (hit !== 1'b1 || {busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
      miscompares++;
      $display("FAIL whack_tick_hit: got %h expected %h", {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
    end
    drive_cycle(0, 0, 0, 0, 100, 280);
    vectors++;
    if (layer_valid !== 1'b1 || layer_rgb !== C_HIT) begin
      miscompares++;
      $display("FAIL frozen_h20_top: got valid=%b rgb=%h expected 1 %h", layer_valid, layer_rgb, C_HIT);
    end
    drive_cycle(0, 0, 1, 1, 100, 279);
    vectors++;
    if (layer_valid !== 1'b0 || hit !== 1'b0 || {busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
      miscompares++;
      $display("FAIL frozen_h20_above: got %h expected %h", {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
    end
    for (int i = 0; i < HIT_FRAMES + 2; i++) begin
      drive_cycle(0, 1, 0, (i == HIT_FRAMES + 1), rx(), ry());
      vectors++;
      if ({busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
        miscompares++;
        $display("FAIL hit_to_fall%0d: got %h expected %h", i, {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid_fall();
    drive_cycle(1, 1, 0, 1, 100, 295);
    vectors++;
    if ({busy, hit, miss, layer_valid, layer_rgb} !== 28'd0) begin
      miscompares++;
      $display("FAIL rst_fall: got %h expected 0000000", {busy, hit, miss, layer_valid, layer_rgb});
    end
    drive_cycle(0, 0, 1, 0, 100, 299);
    vectors++;
    if (busy !== 1'b1 || layer_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL respawn: got busy=%b valid=%b expected 1 0", busy, layer_valid);
    end
    drive_cycle(0, 1, 0, 0, 100, 299);
    drive_cycle(0, 0, 0, 0, 100, 296);
    vectors++;
    if (layer_valid !== 1'b1 || layer_rgb !== C_MOLE) begin
      miscompares++;
      $display("FAIL respawn_h4_in: got valid=%b rgb=%h expected 1 %h", layer_valid, layer_rgb, C_MOLE);
    end
    drive_cycle(0, 0, 0, 0, 100, 295);
    vectors++;
    if (layer_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL respawn_h4_out: got valid=%b expected 0", layer_valid);
    end
  endtask

  task automatic test_spawn_whack_idle();
    drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 1, 100, 299);
    vectors++;
    if (busy !== 1'b1 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL spawn_whack_idle: got busy=%b hit=%b expected 1 0", busy, hit);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0), rx(), ry());
      vectors++;
      if ({busy, hit, miss, layer_valid, layer_rgb} !== exp_vec) begin
        miscompares++;
        $display("FAIL random%0d: got %h expected %h", i, {busy, hit, miss, layer_valid, layer_rgb}, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_whack_hit();
    test_miss();
    test_simultaneous();
    test_reset_mid_fall();
    test_spawn_whack_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
